companion_stat_bank: RTL and testbench

//  Parametrised N-channel companion stat engine with health tracking and a life-cycle FSM.
//  - Each stat channel decays on its own seconds period and is topped up by a refresh pulse.
//  - Health falls while any stat is empty, regenerates while all stats are healthy,
//    and a dead companion freezes until revived.
//  - Sits between the input/button logic and the display/status layer.

---
 rtl/companion_stat_bank.sv | 99 +++++++++
 tb/tb_companion_stat_bank.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/companion_stat_bank.sv
// companion_stat_bank: N-channel decaying stat engine with health tracking and ALIVE/NEEDY/DEAD life cycle
module companion_stat_bank #(
  parameter int CLOCK_FREQ = 125_000_000,
  parameter int NUM_STATS = 3,
  parameter int STAT_WIDTH = 8,
  parameter int STAT_MAX = 100,
  parameter int REFRESH_AMT = 25,
  parameter int LOW_THRESH = 20,
  parameter logic [16*NUM_STATS-1:0] DECAY_SECS = {16'd720, 16'd900, 16'd600},
  parameter int HEALTH_SECS = 300
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            pause,
  input  logic [NUM_STATS-1:0]            refresh,
  input  logic                            revive,
  output logic [NUM_STATS*STAT_WIDTH-1:0] stats,
  output logic [STAT_WIDTH-1:0]           health,
  output logic [NUM_STATS-1:0]            low_flags,
  output logic [1:0]                      state,
  output logic                            dead
);
  typedef enum logic [1:0] {ALIVE = 2'b00, NEEDY = 2'b01, DEAD = 2'b10} state_t;
  localparam int PW = CLOCK_FREQ > 1 ? $clog2(CLOCK_FREQ) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(CLOCK_FREQ - 1);
  localparam logic [STAT_WIDTH-1:0] MAX_V = STAT_WIDTH'(STAT_MAX);
  localparam logic [STAT_WIDTH-1:0] LOW_V = STAT_WIDTH'(LOW_THRESH);
  localparam logic [STAT_WIDTH:0] MAX_W = (STAT_WIDTH+1)'(STAT_MAX);
  localparam logic [STAT_WIDTH:0] REF_W = (STAT_WIDTH+1)'(REFRESH_AMT);
  localparam logic [15:0] H_LAST = 16'(HEALTH_SECS - 1);
  state_t st, nxt;
  logic [PW-1:0] pre;
  logic [15:0] h_cnt;
  logic [15:0] sec_cnt [NUM_STATS];
  logic [STAT_WIDTH-1:0] val [NUM_STATS];
  logic [STAT_WIDTH-1:0] upd [NUM_STATS];
  logic [STAT_WIDTH:0] sum [NUM_STATS];
  logic [STAT_WIDTH-1:0] nh;
  logic [NUM_STATS-1:0] decay;
  logic run, sec_tick, health_step, any_zero, all_ok;
  always_comb begin
    run = !pause && st != DEAD;
    sec_tick = run && pre == P_LAST;
    health_step = sec_tick && h_cnt == H_LAST;
    any_zero = 1'b0;
    all_ok = 1'b1;
    for (int i = 0; i < NUM_STATS; i++) begin
      decay[i] = sec_tick && sec_cnt[i] == DECAY_SECS[16*i +: 16] - 16'd1;
      any_zero = any_zero | (val[i] == '0);
      all_ok = all_ok & (val[i] >= LOW_V);
      sum[i] = {1'b0, val[i]} + REF_W;
      // a refresh wins over a simultaneous decay; the decay is simply dropped
      upd[i] = refresh[i] ? (sum[i] > MAX_W ? MAX_V : sum[i][STAT_WIDTH-1:0]) :
               decay[i] ? (val[i] == '0 ? '0 : val[i] - 1'b1) : val[i];
    end
    nxt = st == ALIVE ? (any_zero ? NEEDY : ALIVE) :
          health == '0 ? DEAD : any_zero ? NEEDY : ALIVE;
    nh = st == ALIVE ? ((!any_zero && health_step && all_ok && health < MAX_V) ? health + 1'b1 : health) :
         ((health != '0 && health_step) ? health - 1'b1 : health);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st <= ALIVE;
      health <= MAX_V;
      pre <= '0;
      h_cnt <= '0;
      for (int i = 0; i < NUM_STATS; i++) begin
        val[i] <= MAX_V;
        sec_cnt[i] <= '0;
      end
    end else if (st == DEAD) begin
      if (revive) begin
        st <= ALIVE;
        health <= MAX_V;
        pre <= '0;
        h_cnt <= '0;
        for (int i = 0; i < NUM_STATS; i++) begin
          val[i] <= MAX_V;
          sec_cnt[i] <= '0;
        end
      end
    end else begin
      st <= nxt;
      health <= nh;
      if (run) pre <= sec_tick ? '0 : pre + 1'b1;
      h_cnt <= (nxt != st || health_step) ? '0 : sec_tick ? h_cnt + 16'd1 : h_cnt;
      for (int i = 0; i < NUM_STATS; i++) begin
        if (sec_tick) sec_cnt[i] <= decay[i] ? '0 : sec_cnt[i] + 16'd1;
        val[i] <= upd[i];
      end
    end
  end
  for (genvar g = 0; g < NUM_STATS; g++) begin : g_out
    assign stats[g*STAT_WIDTH +: STAT_WIDTH] = val[g];
    assign low_flags[g] = val[g] < LOW_V;
  end
  assign state = st;
  assign dead = st == DEAD;
endmodule

// File: tb/tb_companion_stat_bank.sv
// tb_companion_stat_bank: randomized and directed checks against a seconds-based reference model
module tb_companion_stat_bank;
  localparam int CF = 4, MX = 10, RA = 4, LT = 3, HS = 2;
  localparam int DS [3] = '{1, 2, 3};
  logic clk = 0, rst = 0, pause = 0, revive = 0;
  logic [2:0] refresh = '0;
  logic [23:0] stats;
  logic [7:0] health;
  logic [2:0] low_flags;
  logic [1:0] state;
  logic dead;
  logic [37:0] obs, expv;
  int checks = 0, failures = 0;
  int m_stat [3];
  int m_health, m_state, m_cyc, m_secs, m_ssecs;

  companion_stat_bank #(.CLOCK_FREQ(CF), .NUM_STATS(3), .STAT_WIDTH(8), .STAT_MAX(MX),
    .REFRESH_AMT(RA), .LOW_THRESH(LT), .DECAY_SECS({16'd3, 16'd2, 16'd1}), .HEALTH_SECS(HS))
  dut (.clk(clk), .rst(rst), .pause(pause), .refresh(refresh), .revive(revive), .stats(stats),
    .health(health), .low_flags(low_flags), .state(state), .dead(dead));

  always #5 clk = ~clk;
  assign obs = {stats, health, low_flags, state, dead};
  assign expv = exp_vec();

  function automatic logic [37:0] exp_vec();
    logic [2:0] lf;
    for (int i = 0; i < 3; i++) lf[i] = m_stat[i] < LT;
    return {8'(m_stat[2]), 8'(m_stat[1]), 8'(m_stat[0]), 8'(m_health), lf, 2'(m_state), m_state == 2};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) m_stat[i] = MX;
    m_health = MX; m_state = 0; m_cyc = 0; m_secs = 0; m_ssecs = 0;
  endtask

  // one clock of the model: time is tracked as running cycles and elapsed seconds
  task automatic model_step(input logic [2:0] r, input logic rv, input logic p);
    bit running, tick, hstep, any_zero, all_ok;
    int nst, nh;
    running = !p && m_state != 2;
    tick = running && ((m_cyc + 1) % CF == 0);
    hstep = tick && ((m_ssecs + 1) % HS == 0);
    if (m_state == 2) begin
      if (rv) begin
        model_reset();
      end
      return;
    end
    any_zero = 0; all_ok = 1;
    for (int i = 0; i < 3; i++) begin
      any_zero |= m_stat[i] == 0;
      all_ok &= m_stat[i] >= LT;
    end
    nst = m_state; nh = m_health;
    if (m_state == 0) begin
      if (any_zero) nst = 1;
      else if (hstep && all_ok) nh = (m_health + 1 > MX) ? MX : m_health + 1;
    end else begin
      if (m_health == 0) nst = 2;
      else begin
        if (!any_zero) nst = 0;
        if (hstep) nh = m_health - 1;
      end
    end
    for (int i = 0; i < 3; i++) begin
      if (r[i]) m_stat[i] = (m_stat[i] + RA > MX) ? MX : m_stat[i] + RA;
      else if (tick && ((m_secs + 1) % DS[i] == 0) && m_stat[i] > 0) m_stat[i]--;
    end
    if (running) m_cyc++;
    if (tick) begin m_secs++; m_ssecs++; end
    if (nst != m_state) m_ssecs = 0;
    m_state = nst; m_health = nh;
  endtask

  task automatic step(input logic [2:0] r, input logic rv, input logic p);
    refresh = r; revive = rv; pause = p;
    model_step(r, rv, p);
    @(posedge clk);
    #1;
    refresh = '0; revive = 0;
  endtask

  task automatic do_reset();
    rst = 0; pause = 0; refresh = '0; revive = 0;
    model_reset();
    @(posedge clk); #1;
    rst = 1;
  endtask

  task automatic test_reset();
    do_reset();
    if (obs !== expv) begin failures++; $display("FAIL reset obs=%h exp=%h", obs, expv); end
    checks++;
    if (stats !== {8'd10, 8'd10, 8'd10} || health !== 8'd10 || state !== 2'b00 || dead !== 1'b0) begin
      failures++; $display("FAIL reset_const stats=%h health=%0d state=%0d", stats, health, state);
    end
    checks++;
  endtask

  task automatic test_decay();
    do_reset();
    for (int c = 1; c <= 42; c++) begin
      step(3'b000, 0, 0);
      if (obs !== expv) begin failures++; $display("FAIL decay cyc=%0d obs=%h exp=%h", c, obs, expv); end
      checks++;
      if (c == 4 && stats[7:0] !== 8'd9) begin failures++; $display("FAIL decay_first ch0=%0d exp=9", stats[7:0]); end
      if (c == 4) checks++;
      if (c == 40 && (stats !== {8'd7, 8'd5, 8'd0} || state !== 2'b00)) begin
        failures++; $display("FAIL decay_40 stats=%h state=%0d exp=070500/0", stats, state);
      end
      if (c == 40) checks++;
      if (c == 41 && state !== 2'b01) begin failures++; $display("FAIL needy_entry state=%0d exp=1", state); end
      if (c == 41) checks++;
    end
  endtask

  task automatic test_refresh();
    do_reset();
    for (int c = 0; c < 8; c++) step(3'b000, 0, 0);
    step(3'b001, 0, 0);
    if (stats[7:0] !== 8'd10 || obs !== expv) begin
      failures++; $display("FAIL refresh_sat ch0=%0d exp=10 obs=%h exp=%h", stats[7:0], obs, expv);
    end
    checks++;
    for (int c = 0; c < 100 && m_stat[0] != 2; c++) step(3'b000, 0, 0);
    if (stats[7:0] !== 8'd2 || low_flags[0] !== 1'b1) begin
      failures++; $display("FAIL low_flag ch0=%0d flag=%b exp=2/1", stats[7:0], low_flags[0]);
    end
    checks++;
    step(3'b001, 0, 0);
    if (stats[7:0] !== 8'd6 || low_flags[0] !== 1'b0 || obs !== expv) begin
      failures++; $display("FAIL refresh_low ch0=%0d flag=%b exp=6/0", stats[7:0], low_flags[0]);
    end
    checks++;
  endtask

  task automatic test_collision();
    do_reset();
    for (int c = 0; c < 23; c++) step(3'b000, 0, 0);
    if (stats[7:0] !== 8'd5) begin failures++; $display("FAIL collide_pre ch0=%0d exp=5", stats[7:0]); end
    checks++;
    step(3'b001, 0, 0);
    if (stats[7:0] !== 8'd9 || obs !== expv) begin
      failures++; $display("FAIL collide ch0=%0d exp=9 obs=%h exp=%h", stats[7:0], obs, expv);
    end
    checks++;
  endtask

  task automatic test_death();
    logic [37:0] frozen;
    do_reset();
    for (int c = 0; c < 400 && m_state != 2; c++) begin
      step(3'b000, 0, 0);
      if (obs !== expv) begin failures++; $display("FAIL death cyc=%0d obs=%h exp=%h", c, obs, expv); end
      checks++;
    end
    if (dead !== 1'b1 || state !== 2'b10 || health !== 8'd0) begin
      failures++; $display("FAIL dead_reached dead=%b state=%0d health=%0d exp=1/2/0", dead, state, health);
    end
    checks++;
    frozen = expv;
    step(3'b111, 0, 0);
    for (int c = 0; c < 100; c++) step(3'b000, 0, 0);
    if (obs !== frozen) begin failures++; $display("FAIL dead_frozen obs=%h exp=%h", obs, frozen); end
    checks++;
  endtask

  task automatic test_revive();
    step(3'b000, 1, 0);
    if (stats !== {8'd10, 8'd10, 8'd10} || health !== 8'd10 || state !== 2'b00 || obs !== expv) begin
      failures++; $display("FAIL revive obs=%h exp=%h", obs, expv);
    end
    checks++;
    for (int c = 1; c <= 4; c++) begin
      step(3'b000, 0, 0);
      if (obs !== expv) begin failures++; $display("FAIL revive_run cyc=%0d obs=%h exp=%h", c, obs, expv); end
      checks++;
    end
    if (stats[7:0] !== 8'd9) begin failures++; $display("FAIL revive_restart ch0=%0d exp=9", stats[7:0]); end
    checks++;
    step(3'b000, 1, 0);
    if (obs !== expv) begin failures++; $display("FAIL revive_alive obs=%h exp=%h", obs, expv); end
    checks++;
  endtask

  task automatic test_pause();
    logic [37:0] held;
    do_reset();
    for (int c = 0; c < 50; c++) step(3'b000, 0, 0);
    held = expv;
    for (int c = 0; c < 200; c++) begin
      step(c == 100 ? 3'b010 : 3'b000, 0, 1);
      if (obs !== expv) begin failures++; $display("FAIL pause cyc=%0d obs=%h exp=%h", c, obs, expv); end
      checks++;
    end
    if (stats[15:8] !== 8'd8 || stats[7:0] !== held[21:14] || health !== held[13:6]) begin
      failures++; $display("FAIL pause_hold ch1=%0d exp=8 ch0=%0d health=%0d", stats[15:8], stats[7:0], health);
    end
    checks++;
    for (int c = 0; c < 20; c++) begin
      step(3'b000, 0, 0);
      if (obs !== expv) begin failures++; $display("FAIL unpause cyc=%0d obs=%h exp=%h", c, obs, expv); end
      checks++;
    end
    #3 rst = 0;
    #1;
    if (obs !== {8'd10, 8'd10, 8'd10, 8'd10, 3'b000, 2'b00, 1'b0}) begin
      failures++; $display("FAIL async_reset obs=%h exp=%h", obs, {8'd10, 8'd10, 8'd10, 8'd10, 6'd0});
    end
    checks++;
    model_reset();
    @(posedge clk); #1;
    rst = 1;
  endtask

  task automatic test_random();
    logic [2:0] r;
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      r = ($urandom_range(0, 15) == 0) ? 3'($urandom) : 3'b000;
      step(r, $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0);
      if (obs !== expv) begin failures++; $display("FAIL random cyc=%0d obs=%h exp=%h", c, obs, expv); end
      checks++;
    end
  endtask

  initial begin
    model_reset();
    #2;
    test_reset();
    test_decay();
    test_refresh();
    test_collision();
    test_death();
    test_revive();
    test_pause();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
